// File: rtl/ram_pkg.sv
// ram_pkg -- shared defaults and FSM state encoding for the RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   state_t                 : arbiter FSM states (IDLE, ISSUE, CAPTURE)
package ram_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way grant logic for the RAM arbiter.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN
//   defined   : on a simultaneous request the requester not granted last wins;
//               the pointer updates on every accepted grant, resets to "last = 1".
//   undefined : fixed priority, requester 0 always wins; no pointer state.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   req0, req1  : requests
//   take        : a grant is being accepted this cycle (pointer update strobe)
//   gnt1        : 1 = requester 1 wins, 0 = requester 0 wins (valid when take)
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt1
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last1;  // 1 = requester 1 was granted last

  assign gnt1 = req1 & (~req0 | ~last1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last1 <= 1'b1;
    else if (take) last1 <= gnt1;
  end
`else
  // Fixed priority needs no state; clock/reset/take are intentionally unused.
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rst_n, take};

  assign gnt1 = req1 & ~req0;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter -- arbitrates two requesters onto one RAM with a registered
// read port. Each transaction takes IDLE -> ISSUE -> CAPTURE (3 cycles).
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (round-robin vs. fixed priority,
// implemented in rr_arb2).
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   req0/1, we0/1               : request and write-enable per requester
//   addr0/1, wdata0/1           : address and write data per requester
//   ack0/1                      : one-cycle completion pulse (CAPTURE)
//   rdata                       : read result, valid with a read ack
//   busy                        : FSM not in IDLE
//   ram_addr, ram_data, ram_we  : shared RAM pins
//   ram_out                     : RAM read data, one cycle after ram_addr
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_out
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_we;
  logic              lat_id;   // granted requester
  logic [DATA_W-1:0] rdata_q;  // last read result, held across writes/idle
  logic              take;
  logic              gnt1;

  // Arbitration only happens in IDLE; requests during ISSUE/CAPTURE wait.
  assign take = (state == IDLE) & (req0 | req1);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .take  (take),
    .gnt1  (gnt1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    ram_we    = 1'b0;
    busy      = (state != IDLE);
    ram_addr  = lat_addr;
    ram_data  = lat_data;
    rdata     = rdata_q;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE: begin
        ram_we    = lat_we;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        ack0      = ~lat_id;
        ack1      = lat_id;
        // RAM output is valid now; present it directly so rdata lines up with ack.
        if (!lat_we) rdata = ram_out;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      lat_id   <= 1'b0;
    end else if (take) begin
      lat_addr <= gnt1 ? addr1  : addr0;
      lat_data <= gnt1 ? wdata1 : wdata0;
      lat_we   <= gnt1 ? we1    : we0;
      lat_id   <= gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              rdata_q <= '0;
    else if (state == CAPTURE && !lat_we)    rdata_q <= ram_out;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter -- self-checking bench for ram_arbiter with a behavioural
// RAM (registered read) and a transaction-level reference model.
module tb_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, ram_we;
  logic [DW-1:0] rdata, ram_data, ram_out;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] mem     [2**AW];
  logic          mem_ready = 1'b0;
  logic [DW-1:0] ref_mem [2**AW];
  int            last_grant = 1;
  logic [DW-1:0] ref_rdata = '0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_out(ram_out)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'((i * 7 + 3) % (2**DW));
  endfunction

  // Shared RAM: write and registered read on the rising edge; not reset.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end
    ram_out <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from requester r, observed for 4 cycles after sampling.
  task automatic run_txn(input int r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit drop_early, input string tag);
    int n_we, n_busy, n_ack, n_other, ack_at;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, rd;
    logic own, oth;
    n_we = 0; n_busy = 0; n_ack = 0; n_other = 0; ack_at = 0;
    wa = '0; wd = '0; rd = '0;
    @(negedge clk);
    if (r == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      own = (r == 0) ? ack0 : ack1;
      oth = (r == 0) ? ack1 : ack0;
      if (ram_we) begin n_we++; wa = ram_addr; wd = ram_data; end
      if (busy) n_busy++;
      if (own) begin n_ack++; if (ack_at == 0) ack_at = c; rd = rdata; end
      if (oth) n_other++;
      if ((c == 1 && drop_early) || own) begin
        if (r == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({tag, ".ack_lat"}, ack_at, 2);
    chk({tag, ".ack_cnt"}, n_ack, 1);
    chk({tag, ".other_ack"}, n_other, 0);
    chk({tag, ".busy_cyc"}, n_busy, 2);
    chk({tag, ".we_cyc"}, n_we, {31'd0, w});
    if (w) begin
      chk({tag, ".ram_addr"}, wa, a);
      chk({tag, ".ram_data"}, wd, d);
      chk({tag, ".rdata_hold"}, rd, ref_rdata);
      ref_mem[a] = d;
    end else begin
      chk({tag, ".rdata"}, rd, ref_mem[a]);
      ref_rdata = ref_mem[a];
    end
    last_grant = r;
  endtask

  initial begin
    int n_ack;
    int w;
    logic [AW-1:0] a0, a1;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(i);

    // Reset state
    #12;
    chk("reset.ack0", ack0, 0);
    chk("reset.ack1", ack1, 0);
    chk("reset.busy", busy, 0);
    chk("reset.ram_we", ram_we, 0);
    chk("reset.ram_addr", ram_addr, 0);
    chk("reset.rdata", rdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic write then cross-requester read
    run_txn(0, 1'b1, 4'h3, 4'hA, 1'b0, "wr3");
    run_txn(1, 1'b0, 4'h3, 4'h0, 1'b0, "rd3");

    // Boundary addresses
    run_txn(0, 1'b1, 4'hF, 4'h5, 1'b0, "wrF");
    run_txn(1, 1'b1, 4'h0, 4'h9, 1'b0, "wr0");
    run_txn(0, 1'b0, 4'hF, 4'h0, 1'b0, "rdF");
    run_txn(1, 1'b0, 4'h0, 4'h0, 1'b0, "rd0");

    // Request dropped right after sampling
    run_txn(0, 1'b0, 4'h3, 4'h0, 1'b1, "drop");

    // Reset during ISSUE of a write to 7
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = ~ref_mem[7];
    @(negedge clk);
    chk("rst.pre_we", ram_we, 1);
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    chk("rst.ack0", ack0, 0);
    chk("rst.ack1", ack1, 0);
    chk("rst.busy", busy, 0);
    chk("rst.ram_we", ram_we, 0);
    chk("rst.ram_addr", ram_addr, 0);
    chk("rst.ram_data", ram_data, 0);
    chk("rst.rdata", rdata, 0);
    last_grant = 1; ref_rdata = '0;
    @(negedge clk); rst_n = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack0 | ack1) n_ack++;
    end
    chk("rst.no_ack", n_ack, 0);
    run_txn(0, 1'b0, 4'h7, 4'h0, 1'b0, "rst_rd7");

    // Both requesters held high: reads from different addresses
    a0 = 4'(($urandom_range(0, 7)));
    a1 = 4'(($urandom_range(8, 15)));
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = a0; addr1 = a1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("both.excl", {31'd0, ack0 & ack1}, 0);
      if (c % 3 == 2) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        w = 1 - last_grant;
`else
        w = 0;
`endif
        chk("both.ack0", ack0, (w == 0) ? 1 : 0);
        chk("both.ack1", ack1, (w == 1) ? 1 : 0);
        chk("both.rdata", rdata, ref_mem[(w == 1) ? a1 : a0]);
        ref_rdata = ref_mem[(w == 1) ? a1 : a0];
        last_grant = w;
      end else begin
        chk("both.quiet", {31'd0, ack0 | ack1}, 0);
      end
      if (c == 12) begin req0 = 1'b0; req1 = 1'b0; end
    end

    // Randomized single transactions
    for (int k = 0; k < 40; k++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 2**AW - 1)), DW'($urandom_range(0, 2**DW - 1)),
              ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width in bits.
REQ-002 Parameter DATA_W, default 4, RAM data width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0, req1  input  1 each  transaction request from requester 0 / 1; held high until that requester's ack.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while the matching req is high.
REQ-007 addr0, addr1  input  ADDR_W each  target address per requester.
REQ-008 wdata0, wdata1  input  DATA_W each  write data per requester.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  DATA_W  read result; valid when a read ack is high.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 ram_addr  output  ADDR_W, ram_data  output  DATA_W, ram_we  output  1  drive the shared RAM's address, data and we pins.
REQ-013 ram_out  input  DATA_W  RAM read port; registered inside the RAM, valid one cycle after ram_addr is presented.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, ISSUE and CAPTURE.
REQ-015 IDLE: at a rising edge with req0 or req1 high, the block SHALL pick a winner and latch its addr, wdata and we into internal registers; the FSM SHALL then enter ISSUE. With no request, it SHALL stay in IDLE.
REQ-016 ISSUE: ram_addr and ram_data SHALL come from the latched values, and ram_we SHALL equal the latched we. Next state SHALL be CAPTURE.
REQ-017 CAPTURE: the granted ack SHALL be high for this cycle only; rdata SHALL equal ram_out for a read and keep its previous value for a write. Next state SHALL be IDLE.
REQ-018 ram_we SHALL be 0 in every state except ISSUE; ram_addr and ram_data SHALL hold the last latched values outside ISSUE.
REQ-019 Latency: request sampled at edge N, RAM access during cycle N to N+1, ack during cycle N+1 to N+2; throughput is at most one transaction per 3 cycles.
REQ-020 ack0 and ack1 SHALL never be high in the same cycle.
REQ-021 Arbitration SHALL happen only in IDLE; requests arriving during ISSUE or CAPTURE wait.
REQ-022 If req drops mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-023 A req still high in the IDLE cycle after its ack SHALL be treated as a new transaction.
REQ-024 Address and data SHALL pass through unmodified, with no arithmetic and no wrap logic; every address 0..2^ADDR_W-1 SHALL be legal.

Reset
REQ-025 While rst_n = 0, the block SHALL immediately force: state = IDLE; ack0 = ack1 = busy = ram_we = 0; rdata, ram_addr, ram_data and the latched registers = 0; round-robin pointer = "last granted 1".
REQ-026 A reset during ISSUE or CAPTURE SHALL abort the transaction with no ack; a write is aborted too if reset arrives before the ISSUE edge.

Configuration
REQ-027 With macro RAM_ARB_ROUND_ROBIN_EN defined, a simultaneous request SHALL go to the requester not granted last; the pointer SHALL update on every grant.
REQ-028 With RAM_ARB_ROUND_ROBIN_EN undefined, requester 0 SHALL always win; the pointer register SHALL not exist.

Structure
REQ-029 Package ram_pkg SHALL hold ADDR_W and DATA_W defaults and the FSM state typedef (IDLE, ISSUE, CAPTURE).
REQ-030 Sub-module rr_arb2 SHALL contain the 2-way grant logic and pointer; the FSM and datapath registers SHALL stay in ram_arbiter.

Verification
REQ-031 Reset, then req0 write: addr0 = 4'h3, wdata0 = 4'hA -> ram_we high for exactly one cycle with ram_addr = 3 and ram_data = A; ack0 two cycles after the sampling edge; busy high for 2 cycles.
REQ-032 req1 read of addr1 = 4'h3 after that write -> ack1 pulse with rdata = 4'hA; ack0 stays low.
REQ-033 req0 and req1 both held high with the round-robin macro -> grants alternate 0,1,0,1 every 3 cycles; without the macro -> acks go to requester 0 only.
REQ-034 Write address 4'hF = 5, then address 4'h0 = 9, then read both -> rdata 5 and 9, showing boundary addresses are independent.
REQ-035 rst_n pulsed low during ISSUE of a write to address 4'h7 -> no ack; all outputs 0 at once; a later read of address 7 returns its pre-test value.
REQ-036 req0 dropped in the cycle after sampling -> ack0 still pulses, and no second transaction starts.
